score_game_ctrl: RTL and testbench

//  Game-flow sequencer for the score overlay. Counts points per player as single BCD digits and

---
 rtl/pong_pkg.sv | 18 +
 rtl/frame_pause_timer.sv | 32 +++
 rtl/score_game_ctrl.sv | 107 ++++++++++
 tb/tb_score_game_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared game-flow state and overlay text codes for the pong score path
package pong_pkg;

    localparam int WIN_SCORE_DEF = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam logic [1:0] TXT_NONE  = 2'd0;
    localparam logic [1:0] TXT_START = 2'd1;
    localparam logic [1:0] TXT_P1WIN = 2'd2;
    localparam logic [1:0] TXT_P2WIN = 2'd3;

endpackage

// File: rtl/frame_pause_timer.sv
// rtl/frame_pause_timer.sv - frame-tick counter that flags the tick completing the serve pause
module frame_pause_timer #(
    parameter int PAUSE_FRAMES = 120,
    parameter int CNT_W        = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic frame_tick,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PAUSE_FRAMES - 1);

    logic [CNT_W-1:0] count;

    // done coincides with the final tick so the FSM registers PLAY on the following edge
    assign done = frame_tick && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (frame_tick) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_game_ctrl.sv
// rtl/score_game_ctrl.sv - pong game-flow FSM with per-player BCD scores and ball gating
module score_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int PAUSE_FRAMES = 120,
    parameter int CNT_W        = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       miss_p1,
    input  logic       miss_p2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       ball_en,
    output logic       ball_rst,
    output logic [1:0] text_sel,
    output logic [1:0] state
);

    localparam logic [3:0] WIN_DIG = 4'(WIN_SCORE);

    game_state_e state_q, state_n;
    logic [3:0]  dig1_n, dig0_n;
    logic        ball_en_n, ball_rst_n;
    logic [1:0]  text_sel_n;
    logic        pause_done;

    // Counter only runs while serving, so every SERVE entry starts from zero
    frame_pause_timer #(
        .PAUSE_FRAMES(PAUSE_FRAMES),
        .CNT_W       (CNT_W)
    ) u_pause (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q != ST_SERVE),
        .frame_tick(frame_tick),
        .done      (pause_done)
    );

    always_comb begin
        state_n    = state_q;
        dig1_n     = dig1;
        dig0_n     = dig0;
        ball_rst_n = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_n    = ST_SERVE;
                    dig1_n     = 4'd0;
                    dig0_n     = 4'd0;
                    ball_rst_n = 1'b1;
                end
            end
            ST_SERVE: begin
                if (pause_done) begin
                    state_n = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (miss_p1 || miss_p2) begin
                    ball_rst_n = 1'b1;
                    state_n    = ST_SERVE;
                    // a double miss is a dead ball: nobody scores
                    if (miss_p2 && !miss_p1) begin
                        dig1_n = dig1 + 4'd1;
                        if (dig1_n == WIN_DIG) state_n = ST_OVER;
                    end else if (miss_p1 && !miss_p2) begin
                        dig0_n = dig0 + 4'd1;
                        if (dig0_n == WIN_DIG) state_n = ST_OVER;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        ball_en_n = (state_n == ST_PLAY);
        case (state_n)
            ST_IDLE: text_sel_n = TXT_START;
            ST_OVER: text_sel_n = (dig1_n == WIN_DIG) ? TXT_P1WIN : TXT_P2WIN;
            default: text_sel_n = TXT_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dig1     <= 4'd0;
            dig0     <= 4'd0;
            ball_en  <= 1'b0;
            ball_rst <= 1'b0;
            text_sel <= TXT_START;
        end else begin
            state_q  <= state_n;
            dig1     <= dig1_n;
            dig0     <= dig0_n;
            ball_en  <= ball_en_n;
            ball_rst <= ball_rst_n;
            text_sel <= text_sel_n;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_score_game_ctrl.sv
// tb/tb_score_game_ctrl.sv - directed self-checking bench for score_game_ctrl
module tb_score_game_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, frame_tick, miss_p1, miss_p2;
    logic [3:0] dig1, dig0;
    logic       ball_en, ball_rst;
    logic [1:0] text_sel, state;

    int total = 0;
    int bad   = 0;

    score_game_ctrl #(
        .WIN_SCORE   (3),
        .PAUSE_FRAMES(4),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .frame_tick(frame_tick),
        .miss_p1   (miss_p1),
        .miss_p2   (miss_p2),
        .dig1      (dig1),
        .dig0      (dig0),
        .ball_en   (ball_en),
        .ball_rst  (ball_rst),
        .text_sel  (text_sel),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic s, input logic f, input logic m1, input logic m2);
        start = s; frame_tick = f; miss_p1 = m1; miss_p2 = m2;
        @(posedge clk); #1;
        start = 0; frame_tick = 0; miss_p1 = 0; miss_p2 = 0;
    endtask

    task automatic serve_pause();
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        reset = 1; start = 0; frame_tick = 0; miss_p1 = 0; miss_p2 = 0;
        @(posedge clk); #1;
        do_reset();
        check("rst_state", state, 0);
        check("rst_dig1", dig1, 0);
        check("rst_dig0", dig0, 0);
        check("rst_ball_en", ball_en, 0);
        check("rst_ball_rst", ball_rst, 0);
        check("rst_text", text_sel, 1);

        step(0, 1, 1, 1);
        check("idle_ignore_state", state, 0);

        // 1: start
        step(1, 0, 0, 0);
        check("start_state", state, 1);
        check("start_ball_rst", ball_rst, 1);
        check("start_text", text_sel, 0);
        check("start_dig1", dig1, 0);
        step(1, 0, 0, 0);
        check("serve_start_ign", state, 1);
        check("ball_rst_one", ball_rst, 0);

        // 2: serve pause
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("serve3_state", state, 1);
        check("serve3_ball_en", ball_en, 0);
        step(0, 1, 0, 0);
        check("serve4_state", state, 2);
        check("serve4_ball_en", ball_en, 1);

        // 3: P1 scores; a miss in SERVE is ignored
        step(0, 0, 0, 1);
        check("p1pt_dig1", dig1, 1);
        check("p1pt_ball_rst", ball_rst, 1);
        check("p1pt_state", state, 1);
        check("p1pt_ball_en", ball_en, 0);
        step(0, 0, 1, 0);
        check("serve_miss_dig0", dig0, 0);
        serve_pause();
        check("play2_state", state, 2);

        // 4: double miss
        step(0, 0, 1, 1);
        check("dbl_dig1", dig1, 1);
        check("dbl_dig0", dig0, 0);
        check("dbl_state", state, 1);
        check("dbl_ball_rst", ball_rst, 1);
        serve_pause();

        // 5: P2 wins; start on the winning miss is dropped
        step(0, 0, 1, 0);
        check("p2_1", dig0, 1);
        serve_pause();
        step(0, 0, 1, 0);
        check("p2_2", dig0, 2);
        serve_pause();
        step(1, 0, 1, 0);
        check("p2win_dig0", dig0, 3);
        check("p2win_state", state, 3);
        check("p2win_text", text_sel, 3);
        check("p2win_ball_en", ball_en, 0);
        step(0, 1, 1, 1);
        check("over_hold_dig0", dig0, 3);
        check("over_hold_dig1", dig1, 1);
        step(1, 0, 0, 0);
        check("restart_dig0", dig0, 0);
        check("restart_dig1", dig1, 0);
        check("restart_state", state, 1);
        check("restart_ball_rst", ball_rst, 1);

        // P1 win path
        for (int p = 0; p < 3; p++) begin
            serve_pause();
            step(0, 0, 0, 1);
        end
        check("p1win_dig1", dig1, 3);
        check("p1win_state", state, 3);
        check("p1win_text", text_sel, 2);

        // 6: reset mid-play with dig1=2
        step(1, 0, 0, 0);
        serve_pause();
        step(0, 0, 0, 1);
        serve_pause();
        step(0, 0, 0, 1);
        serve_pause();
        check("pre_rst_dig1", dig1, 2);
        check("pre_rst_state", state, 2);
        reset = 1; start = 1; miss_p2 = 1;
        @(posedge clk); #1;
        reset = 0; start = 0; miss_p2 = 0;
        check("mid_rst_state", state, 0);
        check("mid_rst_dig1", dig1, 0);
        check("mid_rst_ball_en", ball_en, 0);
        check("mid_rst_ball_rst", ball_rst, 0);
        check("mid_rst_text", text_sel, 1);

        // reset mid-serve count, then a fresh serve still needs 4 ticks
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check("cnt_cleared_state", state, 1);
        step(0, 1, 0, 0);
        check("cnt_full_state", state, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
